fpu_mul_seq: RTL and testbench

//  Responder end of the FPU operation handshake issued by the convolution engine's FPU_MULT/WAIT/FETCH states.

---
 rtl/fpu_pkg.sv | 45 ++++
 rtl/fpu_round.sv | 63 ++++++
 rtl/fpu_mul_seq.sv | 207 ++++++++++++++++++++
 tb/tb_fpu_mul_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU encodings, binary64 field widths, sequencer state codes and the fixed
// multiply latency that the convolution initiator also counts against.
package fpu_pkg;

  localparam logic [2:0] FPU_OP_ADD = 3'd0;
  localparam logic [2:0] FPU_OP_SUB = 3'd1;
  localparam logic [2:0] FPU_OP_MUL = 3'd2;
  localparam logic [2:0] FPU_OP_DIV = 3'd3;

  localparam logic [1:0] RMODE_NEAREST = 2'b00;
  localparam logic [1:0] RMODE_ZERO    = 2'b01;
  localparam logic [1:0] RMODE_POS_INF = 2'b10;
  localparam logic [1:0] RMODE_NEG_INF = 2'b11;

  localparam int EXP_W    = 11;
  localparam int FRAC_W   = 52;
  localparam int MANT_W   = 53;
  localparam int PROD_W   = 106;
  localparam int EXP_BIAS = 1023;

  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

  localparam int MULT_STEPS = MANT_W;
  localparam int LATENCY    = MULT_STEPS + 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_MULT   = 3'd2;
  localparam logic [2:0] ST_NORM   = 3'd3;
  localparam logic [2:0] ST_ROUND  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] SPEC_NONE = 2'd0;
  localparam logic [1:0] SPEC_NAN  = 2'd1;
  localparam logic [1:0] SPEC_INF  = 2'd2;
  localparam logic [1:0] SPEC_ZERO = 2'd3;

  typedef struct packed {
    logic invalid;
    logic inexact;
    logic overflow;
    logic underflow;
  } fpu_flags_t;

endpackage

// File: rtl/fpu_round.sv
// Combinational binary64 rounder: applies rmode to a normalised mantissa with G/R/S,
// renormalises on carry-out and saturates/flushes out-of-range exponents.
module fpu_round
  import fpu_pkg::*;
(
  input  logic               sign,
  input  logic [MANT_W-1:0]  mant,
  input  logic               guard,
  input  logic               round_bit,
  input  logic               sticky,
  input  logic signed [12:0] exp_in,
  input  logic [1:0]         rmode,
  output logic [63:0]        result,
  output logic               overflow,
  output logic               underflow,
  output logic               inexact
);

  logic               lost;
  logic               inc;
  logic               to_inf;
  logic [MANT_W:0]    mant_sum;
  logic [FRAC_W-1:0]  frac_fin;
  logic signed [12:0] exp_fin;

  always_comb begin
    lost = guard | round_bit | sticky;
    case (rmode)
      RMODE_NEAREST: inc = guard & (round_bit | sticky | mant[0]);
      RMODE_ZERO:    inc = 1'b0;
      RMODE_POS_INF: inc = ~sign & lost;
      default:       inc = sign & lost;
    endcase

    mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    // A carry out of the mantissa leaves 1.000..0, so the fraction is just the shifted sum.
    if (mant_sum[MANT_W]) begin
      frac_fin = mant_sum[MANT_W-1:1];
      exp_fin  = exp_in + 13'sd1;
    end else begin
      frac_fin = mant_sum[FRAC_W-1:0];
      exp_fin  = exp_in;
    end

    to_inf    = (rmode == RMODE_NEAREST) | ((rmode == RMODE_POS_INF) & ~sign) |
                ((rmode == RMODE_NEG_INF) & sign);
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = lost;
    result    = {sign, exp_fin[EXP_W-1:0], frac_fin};

    if (exp_fin >= 13'sd2047) begin
      overflow = 1'b1;
      inexact  = 1'b1;
      result   = to_inf ? {sign, 11'h7FF, 52'h0} : {sign, 11'h7FE, {FRAC_W{1'b1}}};
    end else if (exp_fin <= 13'sd0) begin
      underflow = 1'b1;
      inexact   = 1'b1;
      result    = {sign, 63'h0};
    end
  end

endmodule

// File: rtl/fpu_mul_seq.sv
// Iterative binary64 multiplier slot: one op per enable, fixed 57-cycle accept-to-ready latency.
// No backpressure: enable is only sampled in IDLE; requests arriving while busy are dropped.
module fpu_mul_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready,
  output logic        underflow,
  output logic        overflow,
  output logic        inexact,
  output logic        invalid,
  output logic        exception
);

  logic [2:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [1:0]         rmode_q, rmode_d;
  logic [2:0]         op_q, op_d;
  logic [63:0]        opa_q, opa_d, opb_q, opb_d;
  logic               sign_q, sign_d;
  logic signed [12:0] exp_q, exp_d;
  logic [MANT_W-1:0]  mant_a_q, mant_a_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic [1:0]         spec_q, spec_d;
  logic [MANT_W-1:0]  mant_q, mant_d;
  logic               guard_q, guard_d, rnd_q, rnd_d, sticky_q, sticky_d;
  logic [63:0]        res_q, res_d, out_q, out_d;
  fpu_flags_t         res_flg_q, res_flg_d, flg_q, flg_d;
  logic               ready_q, ready_d;

  logic [MANT_W:0]    step_sum;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [63:0]        rnd_result;
  logic               rnd_of, rnd_uf, rnd_ix;

  fpu_round u_round (
    .sign      (sign_q),
    .mant      (mant_q),
    .guard     (guard_q),
    .round_bit (rnd_q),
    .sticky    (sticky_q),
    .exp_in    (exp_q),
    .rmode     (rmode_q),
    .result    (rnd_result),
    .overflow  (rnd_of),
    .underflow (rnd_uf),
    .inexact   (rnd_ix)
  );

  always_comb begin
    a_zero = (opa_q[62:52] == 11'h000);
    b_zero = (opb_q[62:52] == 11'h000);
    a_inf  = (opa_q[62:52] == 11'h7FF) && (opa_q[51:0] == 52'h0);
    b_inf  = (opb_q[62:52] == 11'h7FF) && (opb_q[51:0] == 52'h0);
    a_nan  = (opa_q[62:52] == 11'h7FF) && (opa_q[51:0] != 52'h0);
    b_nan  = (opb_q[62:52] == 11'h7FF) && (opb_q[51:0] != 52'h0);
    // Shift-add with the multiplier held in the low half of the product register.
    step_sum = {1'b0, prod_q[PROD_W-1:MANT_W]} + (prod_q[0] ? {1'b0, mant_a_q} : '0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rmode_d   = rmode_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_a_d  = mant_a_q;
    prod_d    = prod_q;
    spec_d    = spec_q;
    mant_d    = mant_q;
    guard_d   = guard_q;
    rnd_d     = rnd_q;
    sticky_d  = sticky_q;
    res_d     = res_q;
    res_flg_d = res_flg_q;
    out_d     = out_q;
    flg_d     = flg_q;
    ready_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          opa_d   = opa;
          opb_d   = opb;
          op_d    = fpu_op;
          rmode_d = rmode;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d   = opa_q[63] ^ opb_q[63];
        exp_d    = 13'({2'b00, opa_q[62:52]} + {2'b00, opb_q[62:52]}) - 13'(EXP_BIAS);
        mant_a_d = {1'b1, opa_q[51:0]};
        prod_d   = {{MANT_W{1'b0}}, 1'b1, opb_q[51:0]};
        cnt_d    = 6'd0;
        // Subnormals fall into the zero class, which flushes them without a flag.
        if ((op_q != FPU_OP_MUL) || a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
          spec_d = SPEC_NAN;
        else if (a_inf || b_inf)
          spec_d = SPEC_INF;
        else if (a_zero || b_zero)
          spec_d = SPEC_ZERO;
        else
          spec_d = SPEC_NONE;
        state_d = ST_MULT;
      end
      ST_MULT: begin
        prod_d = {step_sum, prod_q[MANT_W-1:1]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'(MULT_STEPS - 1))
          state_d = ST_NORM;
      end
      ST_NORM: begin
        if (prod_q[PROD_W-1]) begin
          mant_d   = prod_q[105:53];
          guard_d  = prod_q[52];
          rnd_d    = prod_q[51];
          sticky_d = |prod_q[50:0];
          exp_d    = exp_q + 13'sd1;
        end else begin
          mant_d   = prod_q[104:52];
          guard_d  = prod_q[51];
          rnd_d    = prod_q[50];
          sticky_d = |prod_q[49:0];
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        res_flg_d = '0;
        case (spec_q)
          SPEC_NAN: begin
            res_d             = QNAN64;
            res_flg_d.invalid = 1'b1;
          end
          SPEC_INF:  res_d = {sign_q, 11'h7FF, 52'h0};
          SPEC_ZERO: res_d = {sign_q, 63'h0};
          default: begin
            res_d               = rnd_result;
            res_flg_d.overflow  = rnd_of;
            res_flg_d.underflow = rnd_uf;
            res_flg_d.inexact   = rnd_ix;
          end
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_d   = res_q;
        flg_d   = res_flg_q;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= 64'h0;
      flg_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flg_q   <= flg_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    rmode_q   <= rmode_d;
    op_q      <= op_d;
    opa_q     <= opa_d;
    opb_q     <= opb_d;
    sign_q    <= sign_d;
    exp_q     <= exp_d;
    mant_a_q  <= mant_a_d;
    prod_q    <= prod_d;
    spec_q    <= spec_d;
    mant_q    <= mant_d;
    guard_q   <= guard_d;
    rnd_q     <= rnd_d;
    sticky_q  <= sticky_d;
    res_q     <= res_d;
    res_flg_q <= res_flg_d;
  end

  assign out       = out_q;
  assign ready     = ready_q;
  assign underflow = flg_q.underflow;
  assign overflow  = flg_q.overflow;
  assign inexact   = flg_q.inexact;
  assign invalid   = flg_q.invalid;
  assign exception = |flg_q;

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Bench for fpu_mul_seq: directed binary64 vectors, expected results queued at issue and
// checked by an independent monitor on each ready pulse (value, flags, latency, pulse width).
module tb_fpu_mul_seq;

  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] SIX   = 64'h4018_0000_0000_0000;
  localparam logic [63:0] ONEP  = 64'h3FF0_0000_0000_0001;
  localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] BIG   = 64'h7FE0_0000_0000_0000;
  localparam logic [63:0] NBIG  = 64'hFFE0_0000_0000_0000;
  localparam logic [63:0] PINF  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF  = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] PMAX  = 64'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NMAX  = 64'hFFEF_FFFF_FFFF_FFFF;
  localparam logic [63:0] QN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] SNAN  = 64'h7FF0_0000_0000_0001;
  localparam logic [63:0] MINN  = 64'h0010_0000_0000_0000;
  localparam logic [63:0] P15   = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] M15   = 64'hBFF8_0000_0000_0000;
  localparam logic [63:0] M225  = 64'hC002_0000_0000_0000;
  localparam logic [63:0] MTWO  = 64'hC000_0000_0000_0000;
  localparam logic [63:0] NZERO = 64'h8000_0000_0000_0000;
  localparam logic [63:0] FIVE  = 64'h4014_0000_0000_0000;
  localparam logic [63:0] SUBN  = 64'h0000_0000_0000_0001;

  // Flag vectors ordered {invalid, inexact, overflow, underflow}.
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_IX   = 4'b0100;
  localparam logic [3:0] F_OF   = 4'b0110;
  localparam logic [3:0] F_UF   = 4'b0101;
  localparam logic [3:0] F_INV  = 4'b1000;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flg;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  rmode = 2'b00;
  logic [2:0]  fpu_op = 3'd2;
  logic [63:0] opa = 64'h0;
  logic [63:0] opb = 64'h0;
  logic [63:0] out;
  logic        ready, underflow, overflow, inexact, invalid, exception;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_rdy = 1'b0;
  exp_t sb[$];

  fpu_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rmode     (rmode),
    .fpu_op    (fpu_op),
    .opa       (opa),
    .opb       (opb),
    .out       (out),
    .ready     (ready),
    .underflow (underflow),
    .overflow  (overflow),
    .inexact   (inexact),
    .invalid   (invalid),
    .exception (exception)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (prev_rdy) chk("ready_pulse_width", {63'h0, ready}, 64'h0);
    prev_rdy = (ready === 1'b1);
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'h1, 64'h0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_out"}, out, e.res);
        chk({e.name, "_flags"}, {60'h0, invalid, inexact, overflow, underflow}, {60'h0, e.flg});
        chk({e.name, "_exception"}, {63'h0, exception}, {63'h0, |e.flg});
        chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'd57);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic push, input logic [2:0] op, input logic [1:0] rm,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] res,
                       input logic [3:0] flg, input string name, output int acc);
    exp_t e;
    enable = 1'b1;
    fpu_op = op;
    rmode  = rm;
    opa    = a;
    opb    = b;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    acc    = cyc;
    // Scramble inputs after accept so only captured values can produce the result.
    opa    = ~a;
    opb    = ~b;
    rmode  = ~rm;
    fpu_op = 3'd7;
    if (push) begin
      e.res  = res;
      e.flg  = flg;
      e.acc  = acc;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(sb.size()), 64'h0);
    sb.delete();
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] rm, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] res, input logic [3:0] flg,
                     input string name);
    int acc;
    issue(1'b1, op, rm, a, b, res, flg, name, acc);
    wait_empty();
  endtask

  initial begin
    int acc_a, acc_c;
    repeat (3) @(negedge clk);
    chk("reset_out", out, 64'h0);
    chk("reset_ready", {63'h0, ready}, 64'h0);
    chk("reset_flags", {59'h0, exception, invalid, inexact, overflow, underflow}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    run(3'd2, 2'd0, TWO, THREE, SIX, F_NONE, "t1_2x3");
    run(3'd2, 2'd0, ONEP, ONEP, 64'h3FF0_0000_0000_0002, F_IX, "t2_rne");
    run(3'd2, 2'd2, ONEP, ONEP, 64'h3FF0_0000_0000_0003, F_IX, "t2_rpinf");
    run(3'd2, 2'd1, ONEP, ONEP, 64'h3FF0_0000_0000_0002, F_IX, "t2_rz");
    run(3'd2, 2'd3, ONEP, ONEP, 64'h3FF0_0000_0000_0002, F_IX, "t2_rninf");
    run(3'd2, 2'd1, BIG, TWO, PMAX, F_OF, "t3_of_rz");
    run(3'd2, 2'd2, NBIG, TWO, NMAX, F_OF, "t3_of_neg_rpinf");
    run(3'd2, 2'd3, NBIG, TWO, NINF, F_OF, "t3_of_neg_rninf");
    run(3'd2, 2'd0, BIG, TWO, PINF, F_OF, "t3_of_rne");

    // Abort an op mid-flight with reset; outputs still hold the overflow result.
    issue(1'b0, 3'd2, 2'd0, ONEP, ONEP, 64'h0, F_NONE, "t6_abort", acc_a);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out", out, 64'h0);
    chk("t6_rst_ready", {63'h0, ready}, 64'h0);
    chk("t6_rst_flags", {59'h0, exception, invalid, inexact, overflow, underflow}, 64'h0);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    run(3'd2, 2'd0, TWO, THREE, SIX, F_NONE, "t6_after");

    run(3'd2, 2'd0, PINF, 64'h0, QN, F_INV, "t4_inf_x_0");
    run(3'd2, 2'd0, 64'h0, NINF, QN, F_INV, "t4_0_x_inf");
    run(3'd2, 2'd0, MINN, MINN, 64'h0, F_UF, "t4_underflow");
    run(3'd0, 2'd0, TWO, THREE, QN, F_INV, "t4_bad_op");
    run(3'd2, 2'd0, SNAN, ONE, QN, F_INV, "nan_in");
    run(3'd2, 2'd0, PINF, MTWO, NINF, F_NONE, "inf_x_neg");
    run(3'd2, 2'd0, NZERO, FIVE, NZERO, F_NONE, "negzero_x_5");
    run(3'd2, 2'd0, SUBN, TWO, 64'h0, F_NONE, "subnormal_flush");
    run(3'd2, 2'd0, M15, P15, M225, F_NONE, "norm_shift");

    // Stray enables while busy must be ignored; then accept back-to-back at T+58.
    issue(1'b1, 3'd2, 2'd0, TWO, THREE, SIX, F_NONE, "t5_first", acc_a);
    repeat (9) @(negedge clk);
    enable = 1'b1; fpu_op = 3'd2; opa = P15; opb = P15;
    @(negedge clk);
    enable = 1'b0;
    repeat (19) @(negedge clk);
    enable = 1'b1; fpu_op = 3'd2; opa = ONEP; opb = ONEP;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clk);
    issue(1'b1, 3'd2, 2'd0, M15, P15, M225, F_NONE, "t5_b2b", acc_c);
    chk("t5_accept_gap", 64'(acc_c - acc_a), 64'd58);
    wait_empty();
    repeat (80) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
